sw_array_ctrl: RTL and testbench

- Sequencer for a linear systolic array of N_PE Smith-Waterman processing elements (affine gap, biased-zero scores).
- Holds the scoring configuration registers and loads one query base per PE.
- Streams the target sequence into PE0 as a contiguous enable burst, then waits for the last PE's valid flag and captures its high score.
- Returns the unbiased score and target length on a valid/ready result port, then resets the array for the next job.

---
 rtl/sw_array_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_sw_array_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_array_ctrl.sv
// sw_array_ctrl: sequencer for a linear systolic array of N_PE Smith-Waterman
// PEs (affine gap, scores biased by ZERO = 2**(SCORE_WIDTH-1)).
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   cfg_we, cfg_*            penalty register write (accepted in IDLE only)
//   match .. gap_extend      registered penalties broadcast to every PE
//   query_valid/ready/base/last  query base stream, one base per PE
//   tgt_valid/ready/base/last    target base stream into PE0
//   arr_query                query base per PE, PE k on bits [2k+1:2k]
//   arr_data, arr_en         target base and enable into PE0
//   arr_rst                  active-low synchronous reset to all PEs
//   arr_high, arr_vld        high score and valid from the last PE
//   res_valid/ready, res_score, res_tlen  unbiased score and target length
//   err                      sticky {timeout, underrun, query_len}
//   busy                     high whenever the sequencer is not IDLE
module sw_array_ctrl #(
  parameter int SCORE_WIDTH   = 12,
  parameter int N_PE          = 16,
  parameter int LEN_WIDTH     = 10,
  parameter int TIMEOUT_SLACK = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [SCORE_WIDTH-1:0] cfg_match,
  input  logic [SCORE_WIDTH-1:0] cfg_mismatch,
  input  logic [SCORE_WIDTH-1:0] cfg_gap_open,
  input  logic [SCORE_WIDTH-1:0] cfg_gap_extend,
  output logic [SCORE_WIDTH-1:0] match,
  output logic [SCORE_WIDTH-1:0] mismatch,
  output logic [SCORE_WIDTH-1:0] gap_open,
  output logic [SCORE_WIDTH-1:0] gap_extend,
  input  logic                   query_valid,
  output logic                   query_ready,
  input  logic [1:0]             query_base,
  input  logic                   query_last,
  input  logic                   tgt_valid,
  output logic                   tgt_ready,
  input  logic [1:0]             tgt_base,
  input  logic                   tgt_last,
  output logic [2*N_PE-1:0]      arr_query,
  output logic [1:0]             arr_data,
  output logic                   arr_en,
  output logic                   arr_rst,
  input  logic [SCORE_WIDTH-1:0] arr_high,
  input  logic                   arr_vld,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SCORE_WIDTH-2:0] res_score,
  output logic [LEN_WIDTH-1:0]   res_tlen,
  output logic [2:0]             err,
  output logic                   busy
);

  localparam logic [SCORE_WIDTH-1:0] ZERO = {1'b1, {(SCORE_WIDTH-1){1'b0}}};
  localparam int DRAIN_LIMIT = N_PE + 1 + TIMEOUT_SLACK;
  localparam int CW = $clog2(DRAIN_LIMIT + 1);
  localparam int QW = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_LIMIT - 1);
  localparam logic [QW-1:0] Q_LAST = QW'(N_PE - 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_LOAD_Q,
    S_STREAM,
    S_DRAIN,
    S_RESULT
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [QW-1:0]          r_q;
  logic [LEN_WIDTH-1:0]   r_tlen;
  logic [SCORE_WIDTH-1:0] r_match, r_mismatch, r_gap_open, r_gap_extend;
  logic                   r_query_ready, r_tgt_ready;
  logic [2*N_PE-1:0]      r_arr_query;
  logic [1:0]             r_arr_data;
  logic                   r_arr_en, r_arr_rst;
  logic                   r_res_valid;
  logic [SCORE_WIDTH-2:0] r_res_score;
  logic [LEN_WIDTH-1:0]   r_res_tlen;
  logic [2:0]             r_err;
  logic                   r_busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_CLEAR;
      r_cnt         <= '0;
      r_q           <= '0;
      r_tlen        <= '0;
      r_match       <= SCORE_WIDTH'(1);
      r_mismatch    <= '1;
      r_gap_open    <= '1;
      r_gap_extend  <= '1;
      r_query_ready <= 1'b0;
      r_tgt_ready   <= 1'b0;
      r_arr_query   <= '0;
      r_arr_data    <= '0;
      r_arr_en      <= 1'b0;
      r_arr_rst     <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_score   <= '0;
      r_res_tlen    <= '0;
      r_err         <= '0;
      r_busy        <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          // arr_rst was driven low on entry; hold it for two cycles.
          if (r_cnt == CW'(1)) begin
            r_state   <= S_IDLE;
            r_arr_rst <= 1'b1;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_IDLE: begin
          if (cfg_we) begin
            r_match      <= cfg_match;
            r_mismatch   <= cfg_mismatch;
            r_gap_open   <= cfg_gap_open;
            r_gap_extend <= cfg_gap_extend;
          end
          // The base presented here is only a start request; it is consumed in LOAD_Q.
          if (query_valid) begin
            r_state       <= S_LOAD_Q;
            r_query_ready <= 1'b1;
            r_q           <= '0;
            r_tlen        <= '0;
            r_busy        <= 1'b1;
          end
        end

        S_LOAD_Q: begin
          if (query_valid) begin
            r_arr_query[{r_q, 1'b0} +: 2] <= query_base;
            r_q <= r_q + QW'(1);
            if (r_q == Q_LAST) begin
              r_state       <= S_STREAM;
              r_query_ready <= 1'b0;
              r_tgt_ready   <= 1'b1;
              if (!query_last) r_err[0] <= 1'b1;
            end else if (query_last) begin
              r_err[0]      <= 1'b1;
              r_query_ready <= 1'b0;
              r_state       <= S_CLEAR;
              r_arr_rst     <= 1'b0;
              r_cnt         <= '0;
            end
          end
        end

        S_STREAM: begin
          if (tgt_valid) begin
            r_arr_data <= tgt_base;
            r_arr_en   <= 1'b1;
            if (r_tlen != '1) r_tlen <= r_tlen + LEN_WIDTH'(1);
            if (tgt_last) begin
              r_state     <= S_DRAIN;
              r_tgt_ready <= 1'b0;
              r_cnt       <= '0;
            end
          end else begin
            r_arr_en <= 1'b0;
            // tlen saturates and never wraps, so nonzero means a base was accepted.
            // The PEs cannot stall, so a bubble after that ends the target.
            if (r_tlen != '0) begin
              r_err[1]    <= 1'b1;
              r_state     <= S_DRAIN;
              r_tgt_ready <= 1'b0;
              r_cnt       <= '0;
            end
          end
        end

        S_DRAIN: begin
          r_arr_en <= 1'b0;
          if (arr_vld) begin
            // For arr_high >= ZERO, subtracting ZERO just drops the top bit.
            r_res_score <= (arr_high >= ZERO) ? arr_high[SCORE_WIDTH-2:0] : '0;
            r_res_tlen  <= r_tlen;
            r_res_valid <= 1'b1;
            r_state     <= S_RESULT;
          end else if (r_cnt == DRAIN_LAST) begin
            r_err[2]  <= 1'b1;
            r_state   <= S_CLEAR;
            r_arr_rst <= 1'b0;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_CLEAR;
            r_arr_rst   <= 1'b0;
            r_cnt       <= '0;
          end
        end

        default: begin
          r_state   <= S_CLEAR;
          r_arr_rst <= 1'b0;
          r_cnt     <= '0;
        end
      endcase
    end
  end

  assign match       = r_match;
  assign mismatch    = r_mismatch;
  assign gap_open    = r_gap_open;
  assign gap_extend  = r_gap_extend;
  assign query_ready = r_query_ready;
  assign tgt_ready   = r_tgt_ready;
  assign arr_query   = r_arr_query;
  assign arr_data    = r_arr_data;
  assign arr_en      = r_arr_en;
  assign arr_rst     = r_arr_rst;
  assign res_valid   = r_res_valid;
  assign res_score   = r_res_score;
  assign res_tlen    = r_res_tlen;
  assign err         = r_err;
  assign busy        = r_busy;

endmodule

// File: tb/tb_sw_array_ctrl.sv
`timescale 1ns/1ps
module tb_sw_array_ctrl;
  localparam int SW   = 12;
  localparam int NP   = 4;
  localparam int LW   = 10;
  localparam int TS   = 4;
  localparam int ZERO = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          cfg_we = 1'b0;
  logic [SW-1:0] cfg_match = '0, cfg_mismatch = '0, cfg_gap_open = '0, cfg_gap_extend = '0;
  logic [SW-1:0] match, mismatch, gap_open, gap_extend;
  logic          query_valid = 1'b0, query_ready, query_last = 1'b0;
  logic [1:0]    query_base = '0;
  logic          tgt_valid = 1'b0, tgt_ready, tgt_last = 1'b0;
  logic [1:0]    tgt_base = '0;
  logic [2*NP-1:0] arr_query;
  logic [1:0]    arr_data;
  logic          arr_en, arr_rst;
  logic [SW-1:0] arr_high = '0;
  logic          arr_vld = 1'b0;
  logic          res_valid, res_ready = 1'b0;
  logic [SW-2:0] res_score;
  logic [LW-1:0] res_tlen;
  logic [2:0]    err;
  logic          busy;

  sw_array_ctrl #(.SCORE_WIDTH(SW), .N_PE(NP), .LEN_WIDTH(LW), .TIMEOUT_SLACK(TS)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we),
    .cfg_match(cfg_match), .cfg_mismatch(cfg_mismatch),
    .cfg_gap_open(cfg_gap_open), .cfg_gap_extend(cfg_gap_extend),
    .match(match), .mismatch(mismatch), .gap_open(gap_open), .gap_extend(gap_extend),
    .query_valid(query_valid), .query_ready(query_ready), .query_base(query_base),
    .query_last(query_last),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_base(tgt_base), .tgt_last(tgt_last),
    .arr_query(arr_query), .arr_data(arr_data), .arr_en(arr_en), .arr_rst(arr_rst),
    .arr_high(arr_high), .arr_vld(arr_vld),
    .res_valid(res_valid), .res_ready(res_ready), .res_score(res_score), .res_tlen(res_tlen),
    .err(err), .busy(busy)
  );

  // Expected results and queued point checks; only the monitor compares.
  typedef struct packed { logic [SW-2:0] score; logic [LW-1:0] tlen; } exp_t;
  exp_t        sb[$];
  string       cq_name[$];
  logic [31:0] cq_act[$];
  logic [31:0] cq_exp[$];

  int checks = 0;
  int failures = 0;
  int v_cycles = 0;
  int run_len = 0;
  int last_run = 0;

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    cq_name.push_back(name);
    cq_act.push_back(act);
    cq_exp.push_back(exp);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          prev_v = 1'b0, prev_hs = 1'b0;
  logic [SW-2:0] prev_s = '0;
  logic [LW-1:0] prev_t = '0;
  always @(negedge clk) begin
    string       c_name;
    logic [31:0] c_act, c_exp;
    exp_t        e;
    while (cq_name.size() > 0) begin
      c_name = cq_name.pop_front();
      c_act  = cq_act.pop_front();
      c_exp  = cq_exp.pop_front();
      checks++;
      if (c_act !== c_exp) begin
        failures++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", c_name, c_act, c_exp);
      end
    end
    if (res_valid) v_cycles++;
    if (arr_en) run_len++;
    else if (run_len > 0) begin
      last_run = run_len;
      run_len  = 0;
    end
    if (prev_v && !prev_hs && rst) begin
      checks++;
      if ({res_valid, res_score, res_tlen} !== {1'b1, prev_s, prev_t}) begin
        failures++;
        $display("FAIL res_hold: got v=%0b s=%0d t=%0d expected v=1 s=%0d t=%0d",
                 res_valid, res_score, res_tlen, prev_s, prev_t);
      end
    end
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got score=%0d tlen=%0d expected no result",
                 res_score, res_tlen);
      end else begin
        e = sb.pop_front();
        checks += 2;
        if (res_score !== e.score) begin
          failures++;
          $display("FAIL res_score: got %0d expected %0d", res_score, e.score);
        end
        if (res_tlen !== e.tlen) begin
          failures++;
          $display("FAIL res_tlen: got %0d expected %0d", res_tlen, e.tlen);
        end
      end
    end
    prev_v  = res_valid;
    prev_hs = res_valid && res_ready;
    prev_s  = res_score;
    prev_t  = res_tlen;
  end

  // ---------------- behavioural PE array ----------------
  logic [1:0] tq[$];
  int  stub_cnt = 0;
  bit  stub_seen = 1'b0;
  bit  never_vld = 1'b0;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Local affine-gap alignment of arr_query against the streamed target.
  function automatic int sw_score();
    int hp[NP+1], hc[NP+1], ep[NP+1], ec[NP+1];
    int f, s, best, m, mm, go, ge;
    m  = int'($signed(match));
    mm = int'($signed(mismatch));
    go = int'($signed(gap_open));
    ge = int'($signed(gap_extend));
    best = 0;
    for (int i = 0; i <= NP; i++) begin hp[i] = 0; ep[i] = -10000; end
    foreach (tq[j]) begin
      hc[0] = 0; ec[0] = -10000; f = -10000;
      for (int i = 1; i <= NP; i++) begin
        logic [1:0] qb;
        qb    = arr_query[2*(i-1) +: 2];
        ec[i] = imax(hp[i] + go, ep[i] + ge);
        f     = imax(hc[i-1] + go, f + ge);
        s     = hp[i-1] + ((qb == tq[j]) ? m : mm);
        hc[i] = imax(imax(0, s), imax(ec[i], f));
        best  = imax(best, hc[i]);
      end
      for (int i = 0; i <= NP; i++) begin hp[i] = hc[i]; ep[i] = ec[i]; end
    end
    return best;
  endfunction

  always @(negedge clk) begin
    if (!arr_rst) begin
      tq.delete();
      stub_seen = 1'b0;
      stub_cnt  = 0;
      arr_vld   = 1'b0;
      arr_high  = '0;
    end else if (arr_en) begin
      tq.push_back(arr_data);
      stub_seen = 1'b1;
      stub_cnt  = 0;
    end else if (stub_seen && !arr_vld) begin
      stub_cnt++;
      if (stub_cnt == NP && !never_vld) begin
        arr_high = SW'(ZERO + sw_score());
        arr_vld  = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0] q_agtc[NP] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] t_agtc[4]  = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] t_tttt[4]  = '{2'd2, 2'd2, 2'd2, 2'd2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg();
    cfg_match = 12'h002; cfg_mismatch = 12'hFFF; cfg_gap_open = 12'hFFD; cfg_gap_extend = 12'hFFF;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    expect_eq("cfg_penalties", {match, mismatch, gap_open, gap_extend}, 48'h002FFFFFDFFF);
  endtask

  task automatic load_query(input logic [1:0] qb[NP], input int n, input int last_at);
    int idx = 0;
    int guard = 0;
    query_valid = 1'b1;
    while (idx < n && guard < 50) begin
      query_base = qb[idx];
      query_last = (idx == last_at);
      @(negedge clk);
      if (query_ready) idx++;
      guard++;
      tick();
    end
    query_valid = 1'b0;
    query_last  = 1'b0;
    expect_eq("query_accepted", idx, n);
  endtask

  task automatic send_target(input logic [1:0] tb_[4], input int n, input bit use_last,
                             input int pre_gap, input bit hold_valid);
    int idx = 0;
    int guard = 0;
    repeat (pre_gap) tick();
    tgt_valid = 1'b1;
    while (idx < n && guard < 50) begin
      tgt_base = tb_[idx];
      tgt_last = use_last && (idx == n - 1);
      @(negedge clk);
      if (tgt_ready) idx++;
      guard++;
      tick();
    end
    if (!hold_valid) tgt_valid = 1'b0;
    tgt_last = 1'b0;
    expect_eq("target_accepted", idx, n);
  endtask

  task automatic wait_result(input int hold);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
    end
    expect_eq("result_seen", got, 1);
    if (hold > 0) begin
      repeat (hold - 1) @(negedge clk);
      tick();
      res_ready = 1'b1;
      @(negedge clk);
    end
    tick();
    res_ready = 1'b0;
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1'b1;
    end
    expect_eq("reached_idle", got, 1);
  endtask

  task automatic arr_rst_seq(input string name);
    logic [2:0] seq;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seq[2-i] = arr_rst;
    end
    expect_eq(name, seq, 3'b001);
  endtask

  initial begin
    int v0, n;
    // Reset values
    repeat (3) tick();
    @(negedge clk);
    expect_eq("rst_penalties", {match, mismatch, gap_open, gap_extend}, 48'h001FFFFFFFFF);
    expect_eq("rst_ctrl", {arr_rst, arr_en, arr_data, query_ready, tgt_ready, res_valid, busy},
              8'b0_0_00_0_0_0_1);
    expect_eq("rst_data", {arr_query, res_score, res_tlen, err}, 32'h0);
    tick();
    rst = 1'b1;
    arr_rst_seq("rst_clear_len");

    // Job 1: AGTC vs AGTC, target delayed 3 cycles, ready already waiting
    do_cfg();
    load_query(q_agtc, 4, 3);
    expect_eq("arr_query", arr_query, 8'hE4);
    sb.push_back({11'd8, 10'd4});
    res_ready = 1'b1;
    v0 = v_cycles;
    send_target(t_agtc, 4, 1'b1, 3, 1'b0);
    wait_result(0);
    expect_eq("job1_en_run", last_run, 4);
    expect_eq("job1_valid_cycles", v_cycles - v0, 1);
    expect_eq("job1_err", err, 3'b000);
    wait_idle();

    // Job 2: TTTT, cfg_we outside IDLE ignored, result held 5 cycles
    load_query(q_agtc, 4, 3);
    cfg_match = 12'h007;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    expect_eq("cfg_ignored", match, 12'h002);
    sb.push_back({11'd2, 10'd4});
    v0 = v_cycles;
    send_target(t_tttt, 4, 1'b1, 0, 1'b0);
    wait_result(5);
    expect_eq("job2_valid_cycles", v_cycles - v0, 6);
    arr_rst_seq("job2_clear_len");
    expect_eq("job2_err", err, 3'b000);

    // Short query: query_last on the 2nd base
    v0 = v_cycles;
    load_query(q_agtc, 2, 1);
    @(negedge clk);
    expect_eq("shortq_clear", {arr_rst, busy, query_ready, err}, 6'b0_1_0_001);
    wait_idle();
    expect_eq("shortq_idle", {arr_rst, query_ready}, 2'b10);
    expect_eq("shortq_no_result", v_cycles - v0, 0);

    // Underrun after 2 bases
    load_query(q_agtc, 4, 3);
    sb.push_back({11'd4, 10'd2});
    res_ready = 1'b1;
    send_target(t_agtc, 2, 1'b0, 0, 1'b0);
    wait_result(0);
    expect_eq("underrun_en_run", last_run, 2);
    expect_eq("underrun_err", err, 3'b011);
    wait_idle();

    // Timeout: array never raises vld
    never_vld = 1'b1;
    v0 = v_cycles;
    load_query(q_agtc, 4, 3);
    send_target(t_agtc, 4, 1'b1, 0, 1'b0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (err[2]) break;
      n++;
    end
    expect_eq("timeout_drain_cycles", n, 9);
    expect_eq("timeout_clear", {arr_rst, res_valid}, 2'b00);
    wait_idle();
    expect_eq("timeout_err", err, 3'b111);
    expect_eq("timeout_no_result", v_cycles - v0, 0);
    never_vld = 1'b0;

    // Reset mid-STREAM, then a clean job
    load_query(q_agtc, 4, 3);
    send_target(t_agtc, 2, 1'b0, 0, 1'b1);
    rst = 1'b0;
    tick();
    @(negedge clk);
    expect_eq("midrst_ctrl", {arr_rst, arr_en, arr_data, query_ready, tgt_ready, res_valid, busy},
              8'b0_0_00_0_0_0_1);
    expect_eq("midrst_data", {arr_query, res_score, res_tlen, err}, 32'h0);
    expect_eq("midrst_penalties", {match, mismatch, gap_open, gap_extend}, 48'h001FFFFFFFFF);
    tgt_valid = 1'b0;
    tick();
    rst = 1'b1;
    wait_idle();
    do_cfg();
    load_query(q_agtc, 4, 3);
    sb.push_back({11'd8, 10'd4});
    res_ready = 1'b1;
    send_target(t_agtc, 4, 1'b1, 0, 1'b0);
    wait_result(0);
    expect_eq("after_rst_err", err, 3'b000);
    wait_idle();

    expect_eq("scoreboard_empty", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

endmodule
